// File: rtl/nx_bit_pack_pkg.sv
// Shared definitions for the bit packer / unpacker pair.
// Both sides agree on LSB-first bit order: bit 0 of a packed word is the
// first bit of the stream, and field bit 0 is the earliest stream bit.
package nx_bit_pack_pkg;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  // Bit order used on the packed stream by both packer and unpacker.
  localparam bit_order_e BIT_ORDER = ORDER_LSB_FIRST;

  // Width of a field that carries a bit count 0..width inclusive.
  function automatic int size_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Width of a counter that spans 0..width inclusive.
  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/nx_bit_unpack_mask.sv
// Field extraction: keeps the lowest n bits of the holding register and
// zeroes everything above, so a field never carries stale stream bits.
module nx_bit_unpack_mask
  import nx_bit_pack_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [OUT_W-1:0]         buf_low,
  input  logic [size_w(OUT_W)-1:0] n,
  output logic [OUT_W-1:0]         fld_data
);

  // Bit i survives only when it lies below the delivered bit count.
  always_comb begin
    fld_data = '0;
    for (int i = 0; i < OUT_W; i++) begin
      fld_data[i] = buf_low[i] & (i < int'(n));
    end
  end

endmodule

// File: rtl/nx_bit_unpack.sv
// Streaming bit unpacker: packed LSB-first words in, variable-width fields out.
// A single holding register keeps residual bits across word boundaries; the
// end of a stream may return one short field flagged with fld_last.
// Optional feature: define NX_BIT_UNPACK_PEEK_EN to let req_peek return a
// field without consuming it. Without the macro every request consumes.
module nx_bit_unpack
  import nx_bit_pack_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int BUF_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_last,
  input  logic [size_w(IN_W)-1:0]  in_bits,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [size_w(OUT_W)-1:0] req_size,
  input  logic                     req_peek,
  output logic                     fld_valid,
  input  logic                     fld_ready,
  output logic [OUT_W-1:0]         fld_data,
  output logic [size_w(OUT_W)-1:0] fld_size,
  output logic                     fld_last
);

  localparam int SW = size_w(OUT_W);
  localparam int BW = size_w(IN_W);
  localparam int CW = count_w(BUF_W);

  logic [BUF_W-1:0] hold_buf_q;
  logic [BUF_W-1:0] hold_buf_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             last_seen_q;
  logic             last_seen_d;

  logic [SW-1:0]    size_c;
  logic [CW-1:0]    size_cw;
  logic [CW-1:0]    n_cw;
  logic [SW-1:0]    n;
  logic             peek_en;
  logic             req_fire;
  logic             consume;
  logic [CW-1:0]    cons_n;
  logic [CW-1:0]    cnt_after;
  logic             stream_end;
  logic             in_fire;
  logic [BW-1:0]    word_bits;
  logic [IN_W-1:0]  word_data;
  logic [OUT_W-1:0] mask_data;

`ifdef NX_BIT_UNPACK_PEEK_EN
  assign peek_en = req_peek;
`else
  logic unused_peek;
  assign unused_peek = req_peek;
  assign peek_en     = 1'b0;
`endif

  // Clip the request to the widest field and to the bits actually held.
  always_comb begin
    size_c  = (req_size > SW'(OUT_W)) ? SW'(OUT_W) : req_size;
    size_cw = CW'(size_c);
    n_cw    = (cnt_q < size_cw) ? cnt_q : size_cw;
    n       = SW'(n_cw);
  end

  // Handshakes look only at the current fill level, never at same-cycle consume.
  always_comb begin
    in_ready  = !last_seen_q && (cnt_q <= CW'(BUF_W - IN_W));
    req_ready = (!fld_valid || fld_ready) && ((cnt_q >= size_cw) || last_seen_q);
    in_fire   = in_valid && in_ready;
    req_fire  = req_valid && req_ready;
  end

  // Work out how many bits leave the buffer and whether the stream ends here.
  always_comb begin
    consume    = req_fire && !peek_en;
    cons_n     = consume ? n_cw : '0;
    cnt_after  = cnt_q - cons_n;
    stream_end = consume && last_seen_q && (cnt_after == '0);
  end

  // Trim the final word to its valid bits so nothing stale lands in the buffer.
  always_comb begin
    word_bits = '0;
    word_data = '0;
    if (in_last) begin
      word_bits = (in_bits > BW'(IN_W)) ? BW'(IN_W) : in_bits;
    end else begin
      word_bits = BW'(IN_W);
    end
    for (int i = 0; i < IN_W; i++) begin
      word_data[i] = in_data[i] & (i < int'(word_bits));
    end
  end

  // Shift out consumed bits first, then append the new word above the residue.
  always_comb begin
    hold_buf_d  = hold_buf_q >> cons_n;
    cnt_d       = cnt_after;
    last_seen_d = last_seen_q;
    if (in_fire) begin
      hold_buf_d = hold_buf_d | ({{(BUF_W - IN_W){1'b0}}, word_data} << cnt_after);
      cnt_d      = cnt_after + CW'(word_bits);
      if (in_last) begin
        last_seen_d = 1'b1;
      end
    end
    if (stream_end) begin
      hold_buf_d  = '0;
      last_seen_d = 1'b0;
    end
  end

  nx_bit_unpack_mask #(
    .OUT_W (OUT_W)
  ) u_mask (
    .buf_low  (hold_buf_q[OUT_W-1:0]),
    .n        (n),
    .fld_data (mask_data)
  );

  // Holding register, fill count and end-of-stream flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_buf_q  <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
    end else begin
      hold_buf_q  <= hold_buf_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Field output register: loads on accept, holds while stalled, drains on ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fld_valid <= 1'b0;
      fld_data  <= '0;
      fld_size  <= '0;
      fld_last  <= 1'b0;
    end else if (req_fire) begin
      fld_valid <= 1'b1;
      fld_data  <= mask_data;
      fld_size  <= n;
      fld_last  <= stream_end;
    end else if (fld_ready) begin
      fld_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nx_bit_unpack.sv
// Self-checking bench for nx_bit_unpack: directed scenarios plus randomized
// traffic, all compared against a bit-queue reference model.
module tb_nx_bit_unpack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [6:0]  in_bits;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_size;
  logic        req_peek;
  logic        fld_valid;
  logic        fld_ready;
  logic [31:0] fld_data;
  logic [5:0]  fld_size;
  logic        fld_last;

  int checks;
  int failures;

  bit          mq[$];
  bit          m_ls;
  bit          m_fv;
  logic [31:0] m_fd;
  int          m_fs;
  bit          m_fl;

  logic [31:0] obs_fd;
  logic [5:0]  obs_fs;
  logic        obs_fl;

  nx_bit_unpack #(
    .IN_W  (64),
    .OUT_W (32),
    .BUF_W (128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bits   (in_bits),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_size  (req_size),
    .req_peek  (req_peek),
    .fld_valid (fld_valid),
    .fld_ready (fld_ready),
    .fld_data  (fld_data),
    .fld_size  (fld_size),
    .fld_last  (fld_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    mq.delete();
    m_ls = 0;
    m_fv = 0;
    m_fd = '0;
    m_fs = 0;
    m_fl = 0;
  endtask

  // Drive one cycle of inputs, check the DUT against the model, then advance the model.
  task automatic applyStimulus(input bit iv, input logic [63:0] id, input bit il, input int ib,
                               input bit rv, input int rs, input bit rp, input bit fr);
    bit          exp_in_rdy;
    bit          exp_req_rdy;
    bit          peek_eff;
    int          sc;
    int          n;
    int          nb;
    logic [31:0] d;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    in_last   = il;
    in_bits   = 7'(ib);
    req_valid = rv;
    req_size  = 6'(rs);
    req_peek  = rp;
    fld_ready = fr;
    #1;
    sc          = (rs > 32) ? 32 : rs;
    exp_in_rdy  = !m_ls && (mq.size() <= 64);
    exp_req_rdy = (!m_fv || fr) && ((mq.size() >= sc) || m_ls);
    checkOutput("in_ready", in_ready, exp_in_rdy);
    checkOutput("req_ready", req_ready, exp_req_rdy);
    checkOutput("fld_valid", fld_valid, m_fv);
    if (m_fv) begin
      checkOutput("fld_data", fld_data, m_fd);
      checkOutput("fld_size", fld_size, m_fs);
      checkOutput("fld_last", fld_last, m_fl);
    end
    obs_fd = fld_data;
    obs_fs = fld_size;
    obs_fl = fld_last;
`ifdef NX_BIT_UNPACK_PEEK_EN
    peek_eff = rp;
`else
    peek_eff = 0;
`endif
    if (rv && exp_req_rdy) begin
      n = (sc < mq.size()) ? sc : mq.size();
      d = '0;
      for (int i = 0; i < n; i++) d[i] = mq[i];
      if (!peek_eff) begin
        for (int i = 0; i < n; i++) void'(mq.pop_front());
      end
      m_fl = m_ls && !peek_eff && (mq.size() == 0);
      if (m_fl) m_ls = 0;
      m_fv = 1;
      m_fd = d;
      m_fs = n;
    end else if (fr) begin
      m_fv = 0;
    end
    if (iv && exp_in_rdy) begin
      nb = il ? ((ib > 64) ? 64 : ib) : 64;
      for (int i = 0; i < nb; i++) mq.push_back(id[i]);
      if (il) m_ls = 1;
    end
  endtask

  task automatic idle();
    applyStimulus(0, '0, 0, 64, 0, 8, 0, 1);
  endtask

  // Reset asynchronously and verify the cleared outputs while reset is held.
  task automatic doReset();
    @(negedge clk);
    req_valid = 0;
    in_valid  = 0;
    req_size  = 6'd8;
    fld_ready = 1;
    rst = 1;
    #2;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_fld_valid", fld_valid, 0);
    checkOutput("rst_fld_data", fld_data, 0);
    checkOutput("rst_fld_size", fld_size, 0);
    checkOutput("rst_fld_last", fld_last, 0);
    @(negedge clk);
    rst = 0;
    modelClear();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 0;
    in_valid = 0; in_data = '0; in_last = 0; in_bits = 7'd64;
    req_valid = 0; req_size = 6'd8; req_peek = 0; fld_ready = 1;
    modelClear();
    doReset();

    // Contiguous fields across two words.
    applyStimulus(1, 64'hFEDC_BA98_7654_3210, 0, 64, 0, 0, 0, 1);
    applyStimulus(1, 64'h0000_0000_FFFF_FFFF, 0, 64, 1, 4, 0, 1);
    applyStimulus(0, '0, 0, 64, 1, 4, 0, 1);
    checkOutput("contig_f0", obs_fd, 32'h0);
    applyStimulus(0, '0, 0, 64, 1, 8, 0, 1);
    checkOutput("contig_f1", obs_fd, 32'h1);
    applyStimulus(0, '0, 0, 64, 1, 16, 0, 1);
    checkOutput("contig_f2", obs_fd, 32'h32);
    applyStimulus(0, '0, 0, 64, 1, 32, 0, 1);
    checkOutput("contig_f3", obs_fd, 32'h7654);
    idle();
    checkOutput("contig_f4", obs_fd, 32'hFEDC_BA98);

    // Straddle a word boundary with 8 residual bits.
    doReset();
    applyStimulus(1, 64'hAB00_0000_0000_0000, 0, 64, 0, 0, 0, 1);
    applyStimulus(0, '0, 0, 64, 1, 32, 0, 1);
    applyStimulus(0, '0, 0, 64, 1, 24, 0, 1);
    applyStimulus(1, 64'h0000_0000_0000_3456, 0, 64, 0, 0, 0, 1);
    applyStimulus(0, '0, 0, 64, 1, 24, 0, 1);
    idle();
    checkOutput("straddle", obs_fd, 32'h0034_56AB);

    // Drain the rest, then a short final word.
    applyStimulus(0, '0, 0, 64, 1, 32, 0, 1);
    applyStimulus(0, '0, 0, 64, 1, 16, 0, 1);
    applyStimulus(1, 64'hDEAD_0000_0000_0015, 1, 5, 0, 0, 0, 1);
    applyStimulus(0, '0, 0, 64, 1, 8, 0, 1);
    idle();
    checkOutput("short_data", obs_fd, 32'h15);
    checkOutput("short_size", obs_fs, 5);
    checkOutput("short_last", obs_fl, 1);
    checkOutput("short_reopen", in_ready, 1);

    // Backpressure for three cycles, then release.
    applyStimulus(1, 64'h0123_4567_89AB_CDEF, 0, 64, 1, 8, 0, 0);
    applyStimulus(0, '0, 0, 64, 1, 8, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, '0, 0, 64, 1, 8, 0, 0);
    applyStimulus(0, '0, 0, 64, 1, 8, 0, 1);
    idle();
    idle();

    // Fill to the full threshold and overlap a consume with a pending word.
    doReset();
    applyStimulus(1, 64'h1111_2222_3333_4444, 0, 64, 0, 0, 0, 1);
    applyStimulus(1, 64'h5555_6666_7777_8888, 0, 64, 1, 32, 0, 1);
    applyStimulus(1, 64'h9999_AAAA_BBBB_CCCC, 0, 64, 1, 32, 0, 1);
    applyStimulus(1, 64'h9999_AAAA_BBBB_CCCC, 0, 64, 1, 32, 0, 1);
    for (int k = 0; k < 6; k++) applyStimulus(0, '0, 0, 64, 1, 32, 0, 1);

    // Randomized traffic with occasional mid-stream resets.
    doReset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 1500 == 1499) doReset();
      applyStimulus(($urandom_range(0, 3) != 0),
                    {$urandom, $urandom},
                    ($urandom_range(0, 15) == 0),
                    $urandom_range(1, 64),
                    ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 40),
                    $urandom_range(0, 1),
                    ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 20; k++) applyStimulus(0, '0, 0, 64, 1, 32, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nx_bit_unpack.md
# nx_bit_unpack

Streaming bit unpacker: accepts fixed-width packed words (LSB-first bit order) and returns variable-width fields on request, one field per cycle. It is the receive-side counterpart of the packer used on the compressor output path, and sits in front of header/Huffman parsing logic. A single holding register keeps residual bits across word boundaries. End-of-stream handling returns a short final field.

## Interface
- IN_W, 64, input word width
- OUT_W, 32, maximum field width per request
- BUF_W, 128, holding register width; must be >= IN_W + OUT_W
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  IN_W  packed bits, bit 0 consumed first
- in_last  in  1  word is last of stream
- in_bits  in  $clog2(IN_W)+1  valid bits in the last word (1..IN_W); ignored unless in_last
- req_valid  in  1  field request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_size  in  $clog2(OUT_W)+1  requested bits (0..OUT_W); values >OUT_W clip to OUT_W
- req_peek  in  1  return bits without consuming (ignored unless NX_BIT_UNPACK_PEEK_EN)
- fld_valid  out  1  field valid, registered
- fld_ready  in  1  field accepted when fld_valid & fld_ready
- fld_data  out  OUT_W  field bits, zero above fld_size
- fld_size  out  $clog2(OUT_W)+1  delivered bit count
- fld_last  out  1  field consumed final bit of stream

## Operation
- State: buf (BUF_W), cnt (valid bits, 0..BUF_W), last_seen, output register (fld_*).
- Word accept: buf |= in_data << cnt', where cnt' = cnt minus bits consumed the same cycle; cnt += IN_W, or in_bits if in_last; in_last sets last_seen.
- in_ready = !last_seen & (cnt <= BUF_W - IN_W); computed from current cnt, independent of same-cycle consume.
- req_ready = (!fld_valid | fld_ready) & (cnt >= size_c | last_seen), where size_c is the clipped req_size.
- Request accept: fld_data = buf & mask(n), with n = min(size_c, cnt). If not peek: buf >>= n and cnt -= n. fld_size = n.
- Short field: last_seen & cnt < size_c gives fld_size = cnt.
- fld_last = 1 when last_seen & non-peek & cnt - n == 0. That same cycle clears last_seen and buf, which re-opens in_ready for the next stream.
- req_size == 0: fld_size = 0, fld_data = 0, nothing consumed. fld_last is 1 only if last_seen & cnt == 0.
- Simultaneous word accept and consume: shift first, then OR the new word at cnt - n. Both take effect in one cycle.

## Timing
- Reset values: in_ready=1, req_ready=0, fld_valid=0, fld_data=0, fld_size=0, fld_last=0. buf, cnt and last_seen are cleared.
- Reset asserted mid-stream discards all buffered bits and any pending field immediately.
- Request accepted in cycle N gives fld_valid in cycle N+1. With fld_ready held high, throughput is one field per cycle.
- Input word accepted in cycle N is usable by a request in cycle N+1.
- fld_* are held stable while fld_valid & !fld_ready.
- Full: cnt > BUF_W - IN_W deasserts in_ready. Empty (cnt < size_c and !last_seen) deasserts req_ready.

## Configuration
- NX_BIT_UNPACK_PEEK_EN defined: req_peek=1 returns the field without changing buf or cnt, and fld_last stays 0.
- Undefined: req_peek is ignored and every request consumes; the peek mux is not built.

## Structure
- Shared package nx_bit_pack_pkg holds the width helper constants (the size-field width function) and the LSB-first bit-order convention, so packer and unpacker agree.
- One sub-module, nx_bit_unpack_mask: combinational mask/extract (buf, n) -> fld_data. All state stays in the top module.

## Test plan
- Contiguous fields: two words 0x...FEDCBA9876543210 and 0x0000_0000_FFFF_FFFF; requests 4,4,8,16,32 -> 0x0, 0x1, 0x32, 0x7654, then 0xFEDCBA98.
- Straddle: request 24 with cnt=8 (residual 0xAB) and next word low bits 0x3456 -> fld_data 0x3456AB.
- Short last: last word with in_bits=5 (data 0x15); request 8 -> fld_size 5, fld_data 0x15, fld_last=1, then in_ready=1.
- Backpressure: fld_ready=0 for 3 cycles -> fld_* stable, req_ready=0. On release the next field follows in 1 cycle.
- Full/simultaneous: fill cnt to 96 -> in_ready=0. Consume 32 while in_valid -> the word is accepted the following cycle with correct alignment.
- Peek (macro defined): peek 8 twice -> same value both times, cnt unchanged. Consume 8 -> same value again, cnt -= 8.
